spec_free_list_ckpt: RTL and testbench
======================================

# spec_free_list_ckpt

Parametrised speculative physical-register free list for the rename stage, with per-branch checkpoints. Hands out up to DISP_W free registers per cycle and accepts up to COMMIT_W freed registers per cycle, compacted from sparse commit lanes. Snapshots the head pointer at branch rename so a mispredict restores a single checkpoint instead of flushing the whole list. Sits between dispatch/rename and the active list's commit path.

## Interface
- DEPTH, 32: free-list entries (NUM_PHYS - NUM_ARCH).
- NUM_ARCH, 32: architectural registers.
- PHYS_W, 6: physical register id width.
- DISP_W, 4: pop lanes, 1..8.
- COMMIT_W, 4: push lanes, 1..8.
- NUM_CKPT, 4: checkpoint slots, power of 2.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- stall_i  in  1  blocks pops.
- req_i  in  DISP_W  per-lane pop request.
- freed_i  in  COMMIT_W x phys_reg_t  freed register {valid, reg_id} per commit lane.
- free_reg_o  out  DISP_W x PHYS_W  allocated ids.
- empty_o  out  1  fewer than DISP_W entries.
- count_o  out  log2(DEPTH)+1  occupancy.
- recover_i  in  1  full flush.
- ckpt_take_i  in  1  allocate checkpoint.
- ckpt_id_o  out  log2(NUM_CKPT)  id granted to a take this cycle.
- ckpt_full_o  out  1  all slots live.
- ckpt_release_i  in  1  free oldest checkpoint (branch resolved correct).
- restore_i  in  1  mispredict restore.
- restore_id_i  in  log2(NUM_CKPT)  checkpoint to restore.

## Operation
- Reset: entry i = NUM_ARCH+i, head=0, tail=0, count=DEPTH, no live checkpoints. Outputs: empty_o=0, ckpt_full_o=0, ckpt_id_o=0, count_o=DEPTH, free_reg_o = NUM_ARCH..NUM_ARCH+DISP_W-1.
- free_reg_o[i] = entry[(head+i) mod DEPTH]; all zero when empty_o.
- Pop: pop_n = popcount(req_i), applied only if !stall_i && !empty_o; head += pop_n mod DEPTH.
- Push: valid freed lanes compacted in lane order to tail, tail+1, ...; push_n = popcount(valid); pushes never blocked, tail always advances.
- Wrap: pointer sums computed one bit wider, subtract DEPTH if >= DEPTH.
- Checkpoints form a ring (alloc ptr, oldest ptr, live count). Take: slot[alloc] = post-pop head of this cycle; alloc++. Take while ckpt_full_o ignored.
- Release: oldest++; ignored if none live.
- Restore(id): head = slot[id]; count = count + push_n + ((head - slot[id]) mod DEPTH); alloc = id+1, discarding id and all younger checkpoints; id must be live, else ignored. Pops that cycle are dropped.
- Recover: head = post-push tail, count = DEPTH, all checkpoints cleared.
- Priority: reset > recover_i > restore_i > pop/take. Take is ignored in a recover or restore cycle. Release in the same cycle as a restore applies first; a restore of the released id is then ignored.
- Illegal: count + push_n > DEPTH (assertion).

## Timing
- free_reg_o, empty_o, ckpt_id_o, ckpt_full_o are combinational from registered state; zero-cycle allocation.
- head, tail, count, checkpoint state update on posedge clk. Pushed ids are readable the next cycle.
- Restored ids are readable in the cycle after restore_i.

## Structure
- free_list_pkg: phys_reg_t, ckpt_id_t, DEPTH/width localparams.
- Sub-module free_list_ram: DISP_W combinational read ports and COMMIT_W synchronous write ports, flop-based, with reset initialisation.

## Test plan
- Reset, req_i=4'b1111: free_reg_o = 32,33,34,35; next cycle count_o=28 and free_reg_o = 36..39.
- freed_i valid=4'b1010 with ids 5, 9: entries tail, tail+1 = 5, 9; count_o increases by 2.
- Pop to count 3: empty_o=1, free_reg_o all 0, head holds; one push: empty_o deasserts next cycle.
- Take at head=8 with 4 pops, then 6 more pops, then restore that id: head=12 and count_o restored plus any push_n.
- Take 4 checkpoints: ckpt_full_o=1 and a 5th take is ignored; restore id 1 leaves 1 live and ckpt_id_o=2.
- Head at 30 with 4 pops plus recover_i while pushing 2: head = new tail, count_o=32, checkpoints cleared; wrap reads entries 30,31,0,1.

Source files
------------

// File: rtl/spec_free_list_ckpt_pkg.sv
// Shared types and default sizing for the speculative free list.
package spec_free_list_ckpt_pkg;

  localparam int FL_DEPTH    = 32;
  localparam int FL_NUM_ARCH = 32;
  localparam int PHYS_W      = 6;
  localparam int FL_DISP_W   = 4;
  localparam int FL_COMMIT_W = 4;
  localparam int FL_NUM_CKPT = 4;
  localparam int CKPT_W      = $clog2(FL_NUM_CKPT);

  typedef struct packed {
    logic              valid;
    logic [PHYS_W-1:0] id;
  } phys_reg_t;

  typedef logic [CKPT_W-1:0] ckpt_id_t;

  typedef enum logic [1:0] {
    OP_ADVANCE,
    OP_RESTORE,
    OP_RECOVER
  } fl_op_e;

endpackage

// File: rtl/spec_free_list_ckpt_if.sv
// Rename/commit-side bundle of the free list: pops, frees, checkpoint control.
interface spec_free_list_ckpt_if
  import spec_free_list_ckpt_pkg::*;
#(
  parameter int DEPTH    = FL_DEPTH,
  parameter int DISP_W   = FL_DISP_W,
  parameter int COMMIT_W = FL_COMMIT_W,
  parameter int NUM_CKPT = FL_NUM_CKPT
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CK_W  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic                           stall_i;
  logic [DISP_W-1:0]              req_i;
  phys_reg_t [COMMIT_W-1:0]       freed_i;
  logic [DISP_W-1:0][PHYS_W-1:0]  free_reg_o;
  logic                           empty_o;
  logic [CNT_W-1:0]               count_o;
  logic                           recover_i;
  logic                           ckpt_take_i;
  logic [CK_W-1:0]                ckpt_id_o;
  logic                           ckpt_full_o;
  logic                           ckpt_release_i;
  logic                           restore_i;
  logic [CK_W-1:0]                restore_id_i;

  modport master (
    output stall_i, req_i, freed_i, recover_i, ckpt_take_i, ckpt_release_i,
           restore_i, restore_id_i,
    input  free_reg_o, empty_o, count_o, ckpt_id_o, ckpt_full_o
  );

  modport slave (
    input  stall_i, req_i, freed_i, recover_i, ckpt_take_i, ckpt_release_i,
           restore_i, restore_id_i,
    output free_reg_o, empty_o, count_o, ckpt_id_o, ckpt_full_o
  );

endinterface

// File: rtl/spec_free_list_ckpt_ram.sv
// Flop-based free-list storage: combinational reads, synchronous writes,
// reset to the identity mapping NUM_ARCH+i.
module spec_free_list_ckpt_ram
  import spec_free_list_ckpt_pkg::*;
#(
  parameter int DEPTH    = FL_DEPTH,
  parameter int NUM_ARCH = FL_NUM_ARCH,
  parameter int RD_PORTS = FL_DISP_W,
  parameter int WR_PORTS = FL_COMMIT_W,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RD_PORTS-1:0][AW-1:0]      rd_addr_i,
  output logic [RD_PORTS-1:0][PHYS_W-1:0]  rd_data_o,
  input  logic [WR_PORTS-1:0]              wr_en_i,
  input  logic [WR_PORTS-1:0][AW-1:0]      wr_addr_i,
  input  logic [WR_PORTS-1:0][PHYS_W-1:0]  wr_data_i
);
  logic [PHYS_W-1:0] mem_q [DEPTH];
  logic [PHYS_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int unsigned w = 0; w < WR_PORTS; w++) begin
      if (wr_en_i[w]) mem_d[wr_addr_i[w]] = wr_data_i[w];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= PHYS_W'(NUM_ARCH + i);
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < RD_PORTS; r++) rd_data_o[r] = mem_q[rd_addr_i[r]];
  end

endmodule

// File: rtl/spec_free_list_ckpt.sv
// Speculative physical-register free list with a ring of head-pointer
// checkpoints for single-cycle mispredict restore.
module spec_free_list_ckpt
  import spec_free_list_ckpt_pkg::*;
#(
  parameter int DEPTH    = FL_DEPTH,
  parameter int NUM_ARCH = FL_NUM_ARCH,
  parameter int DISP_W   = FL_DISP_W,
  parameter int COMMIT_W = FL_COMMIT_W,
  parameter int NUM_CKPT = FL_NUM_CKPT
) (
  input  logic                 clk,
  input  logic                 reset,
  spec_free_list_ckpt_if.slave fl
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CK_W  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot_q [NUM_CKPT];
  logic [PTR_W-1:0] slot_d [NUM_CKPT];
  logic [CK_W-1:0]  alloc_q, alloc_d, oldest_q, oldest_d;
  logic [CK_W:0]    live_q, live_d;

  logic [CNT_W-1:0] pop_n, push_n, pop_eff;
  logic [PTR_W-1:0] post_pop_head, restore_dist;
  logic [CK_W-1:0]  rst_age;
  logic             rst_live, empty, ckpt_full;
  fl_op_e           op;

  logic [DISP_W-1:0][PTR_W-1:0]    rd_addr;
  logic [DISP_W-1:0][PHYS_W-1:0]   rd_data;
  logic [COMMIT_W-1:0]             wr_en;
  logic [COMMIT_W-1:0][PTR_W-1:0]  wr_addr;
  logic [COMMIT_W-1:0][PHYS_W-1:0] wr_data;

  // b must not exceed DEPTH, so one conditional subtract is enough.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s >= (CNT_W+1)'(DEPTH)) s = s - (CNT_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Sparse commit lanes land at consecutive tail slots in lane order.
  always_comb begin
    push_n = '0;
    for (int unsigned w = 0; w < COMMIT_W; w++) begin
      wr_en[w]   = fl.freed_i[w].valid;
      wr_data[w] = fl.freed_i[w].id;
      wr_addr[w] = wrap_add(tail_q, push_n);
      push_n     = push_n + CNT_W'(fl.freed_i[w].valid);
    end
    pop_n = '0;
    for (int unsigned r = 0; r < DISP_W; r++) begin
      pop_n      = pop_n + CNT_W'(fl.req_i[r]);
      rd_addr[r] = wrap_add(head_q, CNT_W'(r));
    end
  end

  always_comb begin
    oldest_d = oldest_q;
    live_d   = live_q;
    alloc_d  = alloc_q;
    slot_d   = slot_q;
    // Release is applied before the restore liveness check.
    if (fl.ckpt_release_i && live_q != '0) begin
      oldest_d = oldest_q + CK_W'(1);
      live_d   = live_q - (CK_W+1)'(1);
    end
    rst_age  = fl.restore_id_i - oldest_d;
    rst_live = {1'b0, rst_age} < live_d;

    if (fl.recover_i)                  op = OP_RECOVER;
    else if (fl.restore_i && rst_live) op = OP_RESTORE;
    else                               op = OP_ADVANCE;

    pop_eff       = (op == OP_ADVANCE && !fl.stall_i && !empty) ? pop_n : '0;
    post_pop_head = wrap_add(head_q, pop_eff);
    restore_dist  = wrap_add(head_q, CNT_W'(DEPTH) - {1'b0, slot_q[fl.restore_id_i]});
    tail_d        = wrap_add(tail_q, push_n);
    head_d        = post_pop_head;
    count_d       = count_q - pop_eff + push_n;

    case (op)
      OP_RECOVER: begin
        head_d   = tail_d;
        count_d  = CNT_W'(DEPTH);
        alloc_d  = '0;
        oldest_d = '0;
        live_d   = '0;
      end
      OP_RESTORE: begin
        head_d  = slot_q[fl.restore_id_i];
        count_d = count_q + push_n + CNT_W'(restore_dist);
        alloc_d = fl.restore_id_i + CK_W'(1);
        live_d  = {1'b0, rst_age};
      end
      default: begin
        if (fl.ckpt_take_i && !ckpt_full) begin
          slot_d[alloc_q] = post_pop_head;
          alloc_d         = alloc_q + CK_W'(1);
          live_d          = live_d + (CK_W+1)'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= CNT_W'(DEPTH);
      alloc_q  <= '0;
      oldest_q <= '0;
      live_q   <= '0;
      for (int unsigned i = 0; i < NUM_CKPT; i++) slot_q[i] <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      alloc_q  <= alloc_d;
      oldest_q <= oldest_d;
      live_q   <= live_d;
      slot_q   <= slot_d;
    end
  end

  spec_free_list_ckpt_ram #(
    .DEPTH    (DEPTH),
    .NUM_ARCH (NUM_ARCH),
    .RD_PORTS (DISP_W),
    .WR_PORTS (COMMIT_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data)
  );

  assign empty          = count_q < CNT_W'(DISP_W);
  assign ckpt_full      = live_q == (CK_W+1)'(NUM_CKPT);
  assign fl.empty_o     = empty;
  assign fl.count_o     = count_q;
  assign fl.ckpt_id_o   = alloc_q;
  assign fl.ckpt_full_o = ckpt_full;

  always_comb begin
    for (int unsigned r = 0; r < DISP_W; r++) fl.free_reg_o[r] = empty ? '0 : rd_data[r];
  end

  assert property (@(posedge clk) disable iff (reset)
    ({1'b0, count_q} + {1'b0, push_n}) <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_spec_free_list_ckpt.sv
// Directed bench for spec_free_list_ckpt: a small free-list model feeds a
// scoreboard queue that is drained and compared after each clock edge.
module tb_spec_free_list_ckpt;
  import spec_free_list_ckpt_pkg::*;

  localparam int K_COUNT = 0;
  localparam int K_EMPTY = 1;
  localparam int K_REG   = 2;
  localparam int K_CKID  = 3;
  localparam int K_FULL  = 4;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    int unsigned val;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  exp_t        sbq[$];
  int unsigned m_ent [32];
  int unsigned m_head, m_tail, m_count;

  spec_free_list_ckpt_if #(.DEPTH(32), .DISP_W(4), .COMMIT_W(4), .NUM_CKPT(4)) fl ();

  spec_free_list_ckpt #(
    .DEPTH    (32),
    .NUM_ARCH (32),
    .DISP_W   (4),
    .COMMIT_W (4),
    .NUM_CKPT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000;
    $display("FAIL watchdog: got no finish want finish before 5000");
    $fatal(1, "watchdog expired");
  end

  function automatic void expect_val(string tag, int kind, int idx, int unsigned val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sbq.push_back(e);
  endfunction

  function automatic void expect_ck(string tag, int unsigned id, int unsigned full);
    expect_val(tag, K_CKID, 0, id);
    expect_val(tag, K_FULL, 0, full);
  endfunction

  function automatic void expect_state(string tag);
    bit emp;
    emp = (m_count < 4);
    expect_val(tag, K_COUNT, 0, m_count);
    expect_val(tag, K_EMPTY, 0, emp ? 1 : 0);
    for (int i = 0; i < 4; i++)
      expect_val(tag, K_REG, i, emp ? 0 : m_ent[(m_head + i) % 32]);
  endfunction

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      K_COUNT: return 32'(fl.count_o);
      K_EMPTY: return 32'(fl.empty_o);
      K_REG:   return 32'(fl.free_reg_o[idx]);
      K_CKID:  return 32'(fl.ckpt_id_o);
      K_FULL:  return 32'(fl.ckpt_full_o);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.kind, e.idx);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s k%0d[%0d]: got %0d want %0d", e.tag, e.kind, e.idx, o, e.val);
      end
    end
  endtask

  task automatic clear_inputs();
    fl.stall_i        = 1'b0;
    fl.req_i          = '0;
    fl.freed_i        = '0;
    fl.recover_i      = 1'b0;
    fl.ckpt_take_i    = 1'b0;
    fl.ckpt_release_i = 1'b0;
    fl.restore_i      = 1'b0;
    fl.restore_id_i   = '0;
  endtask

  task automatic free_lane(int lane, int unsigned id, bit vld);
    fl.freed_i[lane].valid = vld;
    fl.freed_i[lane].id    = PHYS_W'(id);
  endtask

  // Model the cycle from the driven inputs, queue expectations, clock, compare.
  task automatic step(string tag, bit rst_ok = 1'b0, int unsigned rst_head = 0);
    int unsigned pn, un, old_head;
    un = 0;
    for (int l = 0; l < 4; l++) begin
      if (fl.freed_i[l].valid) begin
        m_ent[m_tail] = 32'(fl.freed_i[l].id);
        m_tail = (m_tail + 1) % 32;
        un++;
      end
    end
    pn = $countones(fl.req_i);
    old_head = m_head;
    if (fl.recover_i) begin
      m_head  = m_tail;
      m_count = 32;
    end else if (fl.restore_i && rst_ok) begin
      m_head  = rst_head;
      m_count = m_count + un + (old_head + 32 - rst_head) % 32;
    end else if (!fl.stall_i && m_count >= 4) begin
      m_head  = (m_head + pn) % 32;
      m_count = m_count - pn + un;
    end else begin
      m_count = m_count + un;
    end
    expect_state(tag);
    @(posedge clk);
    #1;
    clear_inputs();
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < 32; i++) m_ent[i] = 32 + i;
    m_head = 0; m_tail = 0; m_count = 32;
    #22;
    reset = 1'b0;
    expect_state("reset");
    expect_ck("reset", 0, 0);
    drain();

    fl.req_i = 4'b1111;                       step("pop4");
    fl.stall_i = 1'b1; fl.req_i = 4'b1111;    step("stall");
    free_lane(0, 63, 0); free_lane(1, 5, 1);
    free_lane(2, 62, 0); free_lane(3, 9, 1);  step("push2");
    for (int i = 0; i < 6; i++) begin
      fl.req_i = 4'b1111;                     step("drain");
    end
    fl.req_i = 4'b0111;                       step("to3");
    fl.req_i = 4'b1111;                       step("emptyhold");
    free_lane(0, 7, 1);                       step("refill");

    fl.recover_i = 1'b1;
    expect_ck("recover1", 0, 0);              step("recover1");
    fl.req_i = 4'b1111;                       step("pre_take_a");
    fl.req_i = 4'b0001;                       step("pre_take_b");
    expect_ck("pre_take", 0, 0);
    drain();
    fl.req_i = 4'b1111; fl.ckpt_take_i = 1'b1;
    expect_ck("take", 1, 0);                  step("take");
    fl.req_i = 4'b1111;                       step("spec_a");
    fl.req_i = 4'b0011;                       step("spec_b");
    fl.restore_i = 1'b1; fl.restore_id_i = 2'd0;
    fl.req_i = 4'b1111; free_lane(0, 11, 1);
    expect_ck("restore0", 1, 0);              step("restore0", 1'b1, 12);

    fl.recover_i = 1'b1;
    expect_ck("recover2", 0, 0);              step("recover2");
    for (int k = 0; k < 4; k++) begin
      fl.ckpt_take_i = 1'b1; fl.req_i = 4'b0001;
      expect_ck("take4", (k + 1) % 4, (k == 3) ? 1 : 0);
      step("take4");
    end
    fl.ckpt_take_i = 1'b1; fl.req_i = 4'b0001;
    expect_ck("take5", 0, 1);                 step("take5");
    fl.restore_i = 1'b1; fl.restore_id_i = 2'd1; fl.req_i = 4'b1111;
    expect_ck("restore1", 2, 0);              step("restore1", 1'b1, 6);
    for (int k = 0; k < 3; k++) begin
      fl.ckpt_take_i = 1'b1;
      expect_ck("refill_ck", (k + 3) % 4, (k == 2) ? 1 : 0);
      step("refill_ck");
    end
    fl.req_i = 4'b1111;
    expect_ck("pop_full", 1, 1);              step("pop_full");
    fl.ckpt_release_i = 1'b1; fl.restore_i = 1'b1; fl.restore_id_i = 2'd0;
    expect_ck("rel_restore", 1, 0);           step("rel_restore", 1'b0);

    for (int i = 0; i < 5; i++) begin
      fl.req_i = 4'b1111;                     step("to30");
    end
    fl.req_i = 4'b1111; fl.recover_i = 1'b1;
    free_lane(0, 20, 1); free_lane(1, 21, 1);
    expect_ck("recover3", 0, 0);              step("recover3");
    fl.ckpt_take_i = 1'b1;
    expect_ck("after_rec", 1, 0);             step("after_rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
